inst_fetch_unit: RTL

//  Fetch stage of the RV32I core. Holds the PC and issues in-order word reads to instruction memory.

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_fifo.sv | 78 +++++++
 rtl/inst_fetch_unit.sv | 128 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
package fetch_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [XLEN-1:0] INST_NOP         = 32'h0000_0013;

   // One buffered fetch: the instruction word together with the PC it came from.
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
   } fetch_entry_t;

   // Sequential next PC; wraps naturally from FFFF_FFFC to 0.
   function automatic logic [XLEN-1:0] next_word_pc(input logic [XLEN-1:0] cur_pc);
      return cur_pc + XLEN'(4);
   endfunction

   // Word-align a jump/branch target by clearing the byte offset.
   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] target);
      return target & ~XLEN'(3);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO with push/pop/flush, occupancy count and registered head.
// The same push and pop may happen in one cycle; a pop frees the slot a
// simultaneous push uses, so a full FIFO can still accept when it is popped.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int  DEPTH = 2,
   parameter type T     = logic [31:0],
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  T                 push_data,
   input  logic             pop,
   input  logic             flush,
   output T                 head,
   output logic [CNT_W-1:0] occupancy
);

   T                 mem_q [DEPTH];
   T                 mem_d [DEPTH];
   logic [PTR_W-1:0] rd_q, rd_d;
   logic [PTR_W-1:0] wr_q, wr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Next-state for storage, pointers and count; flush empties the FIFO outright.
   always_comb begin
      mem_d   = mem_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      cnt_d   = cnt_q;
      do_pop  = pop && (cnt_q != '0);
      do_push = push && ((cnt_q != CNT_W'(DEPTH)) || do_pop);
      if (flush) begin
         rd_d  = '0;
         wr_d  = '0;
         cnt_d = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_q] = push_data;
            wr_d        = ptr_inc(wr_q);
         end
         if (do_pop) begin
            rd_d = ptr_inc(rd_q);
         end
         cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // State registers; storage is cleared on reset so the head reads as zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   end

   assign head      = mem_q[rd_q];
   assign occupancy = cnt_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// RV32I fetch stage: owns the PC, issues in-order word reads to instruction
// memory under a credit limit, buffers returned words with their PCs and
// presents them to decode. Redirects flush the buffer and squash every
// response still outstanding.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends combinationally on ready of the same channel.
module inst_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter int              BUF_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [XLEN-1:0] inst,
   output logic [XLEN-1:0] pc
);

   localparam int CNT_W = $clog2(BUF_DEPTH + 1);

   logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
   logic [CNT_W-1:0] inflight_q, inflight_d;
   logic [CNT_W-1:0] kill_cnt_q, kill_cnt_d;

   logic [CNT_W-1:0] buf_occ;
   logic [CNT_W-1:0] pc_occ;
   logic [CNT_W:0]   credits_used;
   logic             req_accept;
   logic             rsp_kill;
   logic             buf_push;
   logic             buf_pop;
   logic [XLEN-1:0]  rsp_pc;
   fetch_entry_t     buf_in;
   fetch_entry_t     buf_head;

   // Credit check: every slot is either buffered or reserved by a request in
   // flight, so a response always has room. Requests pause during a redirect.
   always_comb begin
      credits_used   = {1'b0, inflight_q} + {1'b0, buf_occ};
      imem_req_valid = !rst && !redirect_valid && (credits_used < (CNT_W + 1)'(BUF_DEPTH));
      req_accept     = imem_req_valid && imem_req_ready;
      rsp_kill       = imem_rsp_valid && (kill_cnt_q != '0);
      buf_push       = imem_rsp_valid && !rsp_kill && !redirect_valid;
      buf_pop        = id_valid && id_ready;
      buf_in.pc      = rsp_pc;
      buf_in.inst    = imem_rsp_data;
   end

   // Next PC, in-flight count and squash count.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      inflight_d = inflight_q + CNT_W'(req_accept) - CNT_W'(imem_rsp_valid);
      kill_cnt_d = kill_cnt_q - CNT_W'(rsp_kill);
      if (redirect_valid) begin
         fetch_pc_d = align_pc(redirect_pc);
         // Everything still outstanding after this edge was fetched down the
         // old path (killed or not), so the squash count is simply the new
         // in-flight count; this also absorbs back-to-back redirects.
         kill_cnt_d = inflight_d;
      end else if (req_accept) begin
         fetch_pc_d = next_word_pc(fetch_pc_q);
      end
   end

   // Top-level state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         inflight_q <= '0;
         kill_cnt_q <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         inflight_q <= inflight_d;
         kill_cnt_q <= kill_cnt_d;
      end
   end

   // Addresses of requests in flight, popped by each response (kept or killed).
   fetch_fifo #(
      .DEPTH (BUF_DEPTH),
      .T     (logic [XLEN-1:0])
   ) u_pc_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (req_accept),
      .push_data (fetch_pc_q),
      .pop       (imem_rsp_valid),
      .flush     (1'b0),
      .head      (rsp_pc),
      .occupancy (pc_occ)
   );

   // Instruction buffer toward decode; a redirect drops all entries.
   fetch_fifo #(
      .DEPTH (BUF_DEPTH),
      .T     (fetch_entry_t)
   ) u_inst_buf (
      .clk       (clk),
      .rst       (rst),
      .push      (buf_push),
      .push_data (buf_in),
      .pop       (buf_pop),
      .flush     (redirect_valid),
      .head      (buf_head),
      .occupancy (buf_occ)
   );

   assign imem_addr = fetch_pc_q;
   assign id_valid  = (buf_occ != '0);
   assign inst      = buf_head.inst;
   assign pc        = buf_head.pc;

   // Memory must never answer a request that was not made.
   assert property (@(posedge clk) disable iff (rst) imem_rsp_valid |-> (inflight_q != '0));
   // The PC tracker holds exactly one address per outstanding request.
   assert property (@(posedge clk) disable iff (rst) pc_occ == inflight_q);

endmodule
